inst_fetch_buffer: RTL and testbench

INST_FETCH_BUFFER -- requirements
Module: inst_fetch_buffer

---
 rtl/inst_fetch_buffer.sv | 120 ++++++++++++
 tb/tb_inst_fetch_buffer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer: a circular FIFO that splits 2-slot fetch packets into single instructions.
// Optional same-cycle bypass when empty is enabled by defining INST_FETCH_BUFFER_BYPASS_EN.
module inst_fetch_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_imem_valid,
    output logic        io_imem_ready,
    input  logic [31:0] io_imem_bits_pc,
    input  logic [63:0] io_imem_bits_data,
    input  logic [1:0]  io_imem_bits_mask,
    input  logic        io_imem_bits_xcpt,
    output logic        io_inst_valid,
    input  logic        io_inst_ready,
    output logic [31:0] io_inst_bits_raw,
    output logic [31:0] io_inst_bits_pc,
    output logic        io_inst_bits_xcpt,
    input  logic        io_kill
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]      raw_mem [DEPTH];
    logic [31:0]      pc_mem  [DEPTH];
    logic [DEPTH-1:0] xcpt_mem;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          enq;
    logic          deq;
    logic          fifo_deq;
    logic          byp;
    logic          skip0;
    logic          skip1;
    logic          wr0;
    logic          wr1;
    logic [PW-1:0] wr_idx1;
    logic [1:0]    written;

    // Two free entries are always reserved so a full packet can be taken without back-pressure from the consumer.
    assign io_imem_ready = (count <= CW'(DEPTH - 2)) && !io_kill && !reset;
    assign enq           = io_imem_valid && io_imem_ready;

`ifdef INST_FETCH_BUFFER_BYPASS_EN
    assign byp   = (count == '0) && io_imem_valid && (io_imem_bits_mask != 2'b00) && !io_kill && !reset;
    // The slot handed straight to the consumer must not also be stored.
    assign skip0 = byp && io_inst_ready && io_imem_bits_mask[0];
    assign skip1 = byp && io_inst_ready && !io_imem_bits_mask[0];

    always_comb begin
        io_inst_valid     = (count != '0) && !io_kill && !reset;
        io_inst_bits_raw  = raw_mem[rd_ptr];
        io_inst_bits_pc   = pc_mem[rd_ptr];
        io_inst_bits_xcpt = xcpt_mem[rd_ptr];
        if (byp) begin
            io_inst_valid     = 1'b1;
            io_inst_bits_xcpt = io_imem_bits_xcpt;
            if (io_imem_bits_mask[0]) begin
                io_inst_bits_raw = io_imem_bits_data[31:0];
                io_inst_bits_pc  = io_imem_bits_pc;
            end else begin
                io_inst_bits_raw = io_imem_bits_data[63:32];
                io_inst_bits_pc  = io_imem_bits_pc + 32'd4;
            end
        end
    end
`else
    assign byp   = 1'b0;
    assign skip0 = 1'b0;
    assign skip1 = 1'b0;

    always_comb begin
        io_inst_valid     = (count != '0) && !io_kill && !reset;
        io_inst_bits_raw  = raw_mem[rd_ptr];
        io_inst_bits_pc   = pc_mem[rd_ptr];
        io_inst_bits_xcpt = xcpt_mem[rd_ptr];
    end
`endif

    assign deq      = io_inst_valid && io_inst_ready;
    assign fifo_deq = deq && !byp;

    assign wr0     = enq && io_imem_bits_mask[0] && !skip0;
    assign wr1     = enq && io_imem_bits_mask[1] && !skip1;
    assign wr_idx1 = wr0 ? (wr_ptr + PW'(1)) : wr_ptr;
    assign written = {1'b0, wr0} + {1'b0, wr1};

    always_ff @(posedge clock) begin
        if (wr0) begin
            raw_mem[wr_ptr]  <= io_imem_bits_data[31:0];
            pc_mem[wr_ptr]   <= io_imem_bits_pc;
            xcpt_mem[wr_ptr] <= io_imem_bits_xcpt;
        end
        if (wr1) begin
            raw_mem[wr_idx1]  <= io_imem_bits_data[63:32];
            pc_mem[wr_idx1]   <= io_imem_bits_pc + 32'd4;
            xcpt_mem[wr_idx1] <= io_imem_bits_xcpt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (io_kill) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(written);
            rd_ptr <= rd_ptr + PW'(fifo_deq);
            count  <= count + CW'(written) - CW'(fifo_deq);
        end
    end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Scoreboard bench for inst_fetch_buffer: a negedge monitor models occupancy and instruction order.
module tb_inst_fetch_buffer;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_imem_valid = 1'b0;
    logic        io_imem_ready;
    logic [31:0] io_imem_bits_pc = '0;
    logic [63:0] io_imem_bits_data = '0;
    logic [1:0]  io_imem_bits_mask = '0;
    logic        io_imem_bits_xcpt = 1'b0;
    logic        io_inst_valid;
    logic        io_inst_ready = 1'b0;
    logic [31:0] io_inst_bits_raw;
    logic [31:0] io_inst_bits_pc;
    logic        io_inst_bits_xcpt;
    logic        io_kill = 1'b0;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] raw;
        logic [31:0] pc;
        logic        xcpt;
    } entry_t;

    entry_t sb[$];
    entry_t front;
    logic   exp_ready;
    logic   exp_valid;

    inst_fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clock             (clock),
        .reset             (reset),
        .io_imem_valid     (io_imem_valid),
        .io_imem_ready     (io_imem_ready),
        .io_imem_bits_pc   (io_imem_bits_pc),
        .io_imem_bits_data (io_imem_bits_data),
        .io_imem_bits_mask (io_imem_bits_mask),
        .io_imem_bits_xcpt (io_imem_bits_xcpt),
        .io_inst_valid     (io_inst_valid),
        .io_inst_ready     (io_inst_ready),
        .io_inst_bits_raw  (io_inst_bits_raw),
        .io_inst_bits_pc   (io_inst_bits_pc),
        .io_inst_bits_xcpt (io_inst_bits_xcpt),
        .io_kill           (io_kill)
    );

    always #5 clock = ~clock;

    // Reference model: checks handshakes every cycle and instruction contents whenever one is presented.
    always @(negedge clock) begin
        exp_ready = (sb.size() <= DEPTH - 2) && !io_kill && !reset;
        exp_valid = (sb.size() != 0) && !io_kill && !reset;
`ifdef INST_FETCH_BUFFER_BYPASS_EN
        if (sb.size() == 0 && io_imem_valid && io_imem_bits_mask != 2'b00 && !io_kill && !reset)
            exp_valid = 1'b1;
`endif
        checks++;
        if (io_imem_ready !== exp_ready) begin
            failures++;
            $display("FAIL mon_imem_ready t=%0t: got %b expected %b", $time, io_imem_ready, exp_ready);
        end
        checks++;
        if (io_inst_valid !== exp_valid) begin
            failures++;
            $display("FAIL mon_inst_valid t=%0t: got %b expected %b", $time, io_inst_valid, exp_valid);
        end
        if (reset || io_kill) begin
            sb.delete();
        end else begin
            if (io_imem_valid && exp_ready) begin
                if (io_imem_bits_mask[0]) sb.push_back({io_imem_bits_data[31:0], io_imem_bits_pc, io_imem_bits_xcpt});
                if (io_imem_bits_mask[1]) sb.push_back({io_imem_bits_data[63:32], io_imem_bits_pc + 32'd4, io_imem_bits_xcpt});
            end
            if (exp_valid && sb.size() != 0) begin
                front = sb[0];
                checks++;
                if (io_inst_bits_raw !== front.raw || io_inst_bits_pc !== front.pc || io_inst_bits_xcpt !== front.xcpt) begin
                    failures++;
                    $display("FAIL mon_inst_bits t=%0t: got raw=%h pc=%h x=%b expected raw=%h pc=%h x=%b",
                             $time, io_inst_bits_raw, io_inst_bits_pc, io_inst_bits_xcpt, front.raw, front.pc, front.xcpt);
                end
                if (io_inst_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] pc, input logic [63:0] data,
                         input logic [1:0] mask, input logic x, input logic rdy);
        @(posedge clock);
        #1;
        io_imem_valid     = v;
        io_imem_bits_pc   = pc;
        io_imem_bits_data = data;
        io_imem_bits_mask = mask;
        io_imem_bits_xcpt = x;
        io_inst_ready     = rdy;
    endtask

    task automatic drain();
        drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b1);
        repeat (3 * DEPTH) @(negedge clock);
        checks++;
        if (sb.size() != 0 || dut.count !== '0) begin
            failures++;
            $display("FAIL drain: got sb=%0d count=%0d expected 0 and 0", sb.size(), dut.count);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        checks++;
        if (io_imem_ready !== 1'b0 || io_inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: got ready=%b valid=%b expected 0 0", io_imem_ready, io_inst_valid);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (io_imem_ready !== 1'b1 || io_inst_valid !== 1'b0 || dut.count !== '0 || dut.rd_ptr !== '0 || dut.wr_ptr !== '0) begin
            failures++;
            $display("FAIL reset_release: got ready=%b valid=%b count=%0d rd=%0d wr=%0d expected 1 0 0 0 0",
                     io_imem_ready, io_inst_valid, dut.count, dut.rd_ptr, dut.wr_ptr);
        end
    endtask

    task automatic test_basic();
        drive(1'b1, 32'h1000, 64'h00B00093_00A00013, 2'b11, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_mask();
        drive(1'b1, 32'h2000, 64'hCAFEBABE_DEADBEEF, 2'b10, 1'b0, 1'b1);
        drive(1'b1, 32'h3000, 64'h11111111_22222222, 2'b00, 1'b0, 1'b1);
        @(negedge clock);
        checks++;
        if (io_imem_ready !== 1'b1) begin
            failures++;
            $display("FAIL mask00_ready: got %b expected 1", io_imem_ready);
        end
        drain();
    endtask

    task automatic test_full();
        drive(1'b1, 32'h4000, 64'hA1A1A1A1_A0A0A0A0, 2'b11, 1'b0, 1'b0);
        drive(1'b1, 32'h4008, 64'hA3A3A3A3_A2A2A2A2, 2'b11, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b0);
        @(negedge clock);
        checks++;
        if (dut.count !== 3'd4 || io_imem_ready !== 1'b0 || io_inst_bits_raw !== 32'hA0A0A0A0) begin
            failures++;
            $display("FAIL full: got count=%0d ready=%b raw=%h expected 4 0 a0a0a0a0", dut.count, io_imem_ready, io_inst_bits_raw);
        end
        drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b0);
        @(negedge clock);
        checks++;
        if (io_inst_bits_raw !== 32'hA0A0A0A0 || io_inst_bits_pc !== 32'h4000) begin
            failures++;
            $display("FAIL full_hold: got raw=%h pc=%h expected a0a0a0a0 4000", io_inst_bits_raw, io_inst_bits_pc);
        end
        drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b0);
        @(negedge clock);
        checks++;
        if (dut.count !== 3'd3 || io_imem_ready !== 1'b0) begin
            failures++;
            $display("FAIL deq_one: got count=%0d ready=%b expected 3 0", dut.count, io_imem_ready);
        end
        drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b0);
        @(negedge clock);
        checks++;
        if (dut.count !== 3'd2 || io_imem_ready !== 1'b1) begin
            failures++;
            $display("FAIL deq_two: got count=%0d ready=%b expected 2 1", dut.count, io_imem_ready);
        end
        drain();
    endtask

    task automatic test_kill();
        drive(1'b1, 32'h5000, 64'hB1B1B1B1_B0B0B0B0, 2'b11, 1'b0, 1'b0);
        drive(1'b1, 32'h5008, 64'hB3B3B3B3_B2B2B2B2, 2'b01, 1'b0, 1'b0);
        drive(1'b1, 32'h5010, 64'hB5B5B5B5_B4B4B4B4, 2'b11, 1'b0, 1'b1);
        io_kill = 1'b1;
        @(negedge clock);
        checks++;
        if (io_inst_valid !== 1'b0 || io_imem_ready !== 1'b0) begin
            failures++;
            $display("FAIL kill_same_cycle: got valid=%b ready=%b expected 0 0", io_inst_valid, io_imem_ready);
        end
        @(posedge clock);
        #1;
        io_kill = 1'b0;
        io_imem_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (dut.count !== '0 || dut.rd_ptr !== dut.wr_ptr || io_inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL kill_after: got count=%0d rd=%0d wr=%0d valid=%b expected 0 equal 0",
                     dut.count, dut.rd_ptr, dut.wr_ptr, io_inst_valid);
        end
        drain();
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 32'h6000, 64'hC1C1C1C1_C0C0C0C0, 2'b11, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (dut.count !== '0 || io_inst_valid !== 1'b0 || io_imem_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset: got count=%0d valid=%b ready=%b expected 0 0 1", dut.count, io_inst_valid, io_imem_ready);
        end
    endtask

    task automatic test_xcpt();
        drive(1'b1, 32'h7000, 64'hD1D1D1D1_D0D0D0D0, 2'b11, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b0);
        @(negedge clock);
        checks++;
        if (io_inst_bits_xcpt !== 1'b1) begin
            failures++;
            $display("FAIL xcpt_slot0: got %b expected 1", io_inst_bits_xcpt);
        end
        drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b0);
        @(negedge clock);
        checks++;
        if (io_inst_bits_xcpt !== 1'b1 || io_inst_bits_pc !== 32'h7004) begin
            failures++;
            $display("FAIL xcpt_slot1: got x=%b pc=%h expected 1 7004", io_inst_bits_xcpt, io_inst_bits_pc);
        end
        drain();
    endtask

    task automatic test_random();
        int sent = 0;
        int cycles = 0;
        logic [31:0] pc = {$urandom_range(0, 32'h0FFF_FFFF), 3'b000} & 32'hFFFF_FFF8;
        logic [63:0] data = {$urandom, $urandom};
        logic [1:0]  mask = 2'($urandom_range(0, 3));
        logic        x = 1'($urandom_range(0, 1));
        while (sent < 20 && cycles < 400) begin
            drive(1'b1, pc, data, mask, x, 1'($urandom_range(0, 1)));
            @(negedge clock);
            cycles++;
            if (io_imem_ready) begin
                sent++;
                pc   = $urandom & 32'hFFFF_FFF8;
                data = {$urandom, $urandom};
                mask = 2'($urandom_range(0, 3));
                x    = 1'($urandom_range(0, 1));
            end
        end
        checks++;
        if (sent != 20) begin
            failures++;
            $display("FAIL random_timeout: got %0d packets accepted expected 20", sent);
        end
        drain();
    endtask

    task automatic test_latency();
        drive(1'b1, 32'h8000, 64'hE1E1E1E1_E0E0E0E0, 2'b11, 1'b0, 1'b1);
        @(negedge clock);
        checks++;
`ifdef INST_FETCH_BUFFER_BYPASS_EN
        if (io_inst_valid !== 1'b1 || io_inst_bits_raw !== 32'hE0E0E0E0) begin
            failures++;
            $display("FAIL latency_c0: got valid=%b raw=%h expected 1 e0e0e0e0", io_inst_valid, io_inst_bits_raw);
        end
`else
        if (io_inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL latency_c0: got valid=%b expected 0", io_inst_valid);
        end
`endif
        drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b1);
        @(negedge clock);
        checks++;
`ifdef INST_FETCH_BUFFER_BYPASS_EN
        if (io_inst_valid !== 1'b1 || io_inst_bits_pc !== 32'h8004) begin
            failures++;
            $display("FAIL latency_c1: got valid=%b pc=%h expected 1 8004", io_inst_valid, io_inst_bits_pc);
        end
`else
        if (io_inst_valid !== 1'b1 || io_inst_bits_pc !== 32'h8000) begin
            failures++;
            $display("FAIL latency_c1: got valid=%b pc=%h expected 1 8000", io_inst_valid, io_inst_bits_pc);
        end
`endif
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mask();
        test_full();
        test_kill();
        test_mid_reset();
        test_xcpt();
        test_random();
        test_latency();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
